// File: rtl/softmax_backward.sv
// Softmax backward pass: dx_i = y_i * (g_i - sum_j g_j*y_j), signed fixed point.
// One shared multiplier, one element per cycle, start/busy/done handshake.
module softmax_backward #(
    parameter int VEC_SIZE   = 1,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] y_in     [VEC_SIZE],
    input  logic signed [DATA_WIDTH-1:0] grad_in  [VEC_SIZE],
    output logic                         busy,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] grad_out [VEC_SIZE]
);

    localparam int IW = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
    localparam int AW = DATA_WIDTH + $clog2(VEC_SIZE) + 1;
    localparam int PW = 2 * DATA_WIDTH + 1;
    localparam logic [IW-1:0] LAST = IW'(VEC_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DOT, OUT} state_t;

    state_t                       state_reg, state_next;
    logic [IW-1:0]                idx_reg;
    logic signed [AW-1:0]         acc_reg;
    logic signed [DATA_WIDTH-1:0] s_reg;
    logic                         busy_reg;
    logic                         done_reg;
    logic signed [DATA_WIDTH-1:0] y_reg [VEC_SIZE];
    logic signed [DATA_WIDTH-1:0] g_reg [VEC_SIZE];

    logic signed [DATA_WIDTH-1:0] y_sel;
    logic signed [DATA_WIDTH-1:0] g_sel;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH:0]   mul_b;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         prod_sh;
    logic signed [DATA_WIDTH-1:0] term;
    logic signed [AW-1:0]         acc_sum;
    logic                         last;

    // Clamp to DATA_WIDTH: in range iff all bits above the sign bit match it.
    function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [PW-1:0] v);
        logic [PW-DATA_WIDTH:0] top;
        top = v[PW-1:DATA_WIDTH-1];
        if ((&top) || !(|top))
            return v[DATA_WIDTH-1:0];
        else if (v[PW-1])
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    always_comb begin
        y_sel = '0;
        g_sel = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (idx_reg == IW'(i)) begin
                y_sel = y_reg[i];
                g_sel = g_reg[i];
            end
        end
    end

    // The same multiplier serves the dot product (y*g) and the output pass (y*(g-s)).
    always_comb begin
        diff    = {g_sel[DATA_WIDTH-1], g_sel} - {s_reg[DATA_WIDTH-1], s_reg};
        mul_b   = (state_reg == OUT) ? diff : {g_sel[DATA_WIDTH-1], g_sel};
        prod    = {{(DATA_WIDTH+1){y_sel[DATA_WIDTH-1]}}, y_sel}
                * {{DATA_WIDTH{mul_b[DATA_WIDTH]}}, mul_b};
        prod_sh = prod >>> FIXED_PNT;
        term    = sat_dw(prod_sh);
        acc_sum = acc_reg + AW'(term);
        last    = (idx_reg == LAST);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = DOT;
            DOT:     if (last)  state_next = OUT;
            OUT:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            acc_reg  <= '0;
            s_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            for (int i = 0; i < VEC_SIZE; i++) begin
                y_reg[i]    <= '0;
                g_reg[i]    <= '0;
                grad_out[i] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        idx_reg  <= '0;
                        acc_reg  <= '0;
                        busy_reg <= 1'b1;
                        for (int i = 0; i < VEC_SIZE; i++) begin
                            y_reg[i] <= y_in[i];
                            g_reg[i] <= grad_in[i];
                        end
                    end
                end
                DOT: begin
                    acc_reg <= acc_sum;
                    if (last) begin
                        s_reg   <= sat_dw(PW'(acc_sum));
                        idx_reg <= '0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                OUT: begin
                    for (int i = 0; i < VEC_SIZE; i++)
                        if (idx_reg == IW'(i))
                            grad_out[i] <= term;
                    if (last) begin
                        idx_reg  <= '0;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_softmax_backward.sv
// Directed bench for softmax_backward: VEC_SIZE=4 instance for the main cases,
// VEC_SIZE=1 instance for the degenerate case; one line per checked item.
module tb_softmax_backward;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;
    logic signed [15:0] y4 [4];
    logic signed [15:0] g4 [4];
    logic signed [15:0] go4 [4];
    logic signed [15:0] y1 [1];
    logic signed [15:0] g1 [1];
    logic signed [15:0] go1 [1];
    logic busy4, done4, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    softmax_backward #(.VEC_SIZE(4), .DATA_WIDTH(16), .FIXED_PNT(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y4), .grad_in(g4),
        .busy(busy4), .done(done4), .grad_out(go4)
    );

    softmax_backward #(.VEC_SIZE(1), .DATA_WIDTH(16), .FIXED_PNT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1), .grad_in(g1),
        .busy(busy1), .done(done1), .grad_out(go1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%04h", tag, obs);
        end
    endtask

    task automatic set_in(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        y4[0] = a0; y4[1] = a1; y4[2] = a2; y4[3] = a3;
        g4[0] = b0; g4[1] = b1; g4[2] = b2; g4[3] = b3;
    endtask

    task automatic check_out(input string tag, input logic [15:0] e0, e1, e2, e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++)
            check($sformatf("%s.grad_out[%0d]", tag, k), go4[k], e[k]);
    endtask

    // Pulse start, then wait (bounded) for done; extra start pulses at the
    // given edge offsets, optional input scrambling while busy.
    task automatic run4(input int pa, input int pb, input bit scramble,
                        output int edges, output int bc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bc = busy4 ? 1 : 0;
        edges = 0;
        while (!done4 && edges < 40) begin
            if (edges == pa || edges == pb) start = 1'b1;
            if (scramble) begin
                for (int k = 0; k < 4; k++) begin
                    y4[k] = 16'($urandom);
                    g4[k] = 16'($urandom);
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (busy4) bc++;
        end
    endtask

    initial begin
        int e, b, n, dn;
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        y1[0] = 16'h0;
        g1[0] = 16'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 16'(busy4), 16'd0);
        check("reset.done", 16'(done4), 16'd0);
        check("reset.s", dut4.s_reg, 16'h0000);
        check_out("reset", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic
        set_in(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0100, 16'h0, 16'h0, 16'h0);
        run4(-1, -1, 1'b0, e, b);
        check("basic.latency", 16'(e), 16'd8);
        check("basic.busy_cycles", 16'(b), 16'd8);
        check("basic.done", 16'(done4), 16'd1);
        check("basic.busy_in_done", 16'(busy4), 16'd0);
        check("basic.s", dut4.s_reg, 16'h0040);
        check_out("basic", 16'h0030, 16'hFFF0, 16'hFFF0, 16'hFFF0);
        @(posedge clk);
        #1;
        check("basic.done_one_cycle", 16'(done4), 16'd0);

        // Uniform gradient
        set_in(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        run4(-1, -1, 1'b0, e, b);
        check("uniform.latency", 16'(e), 16'd8);
        check("uniform.s", dut4.s_reg, 16'h0100);
        check_out("uniform", 16'h0, 16'h0, 16'h0, 16'h0);

        // Saturation
        set_in(16'h1000, 16'h0, 16'h0, 16'h0, 16'h0800, 16'h0, 16'h0, 16'h0);
        run4(-1, -1, 1'b0, e, b);
        check("sat.s", dut4.s_reg, 16'h7FFF);
        check_out("sat", 16'h8000, 16'h0, 16'h0, 16'h0);

        // Start pulses while busy are ignored; inputs change while busy
        set_in(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0100, 16'h0, 16'h0, 16'h0);
        run4(3, 5, 1'b1, e, b);
        check("hs.latency", 16'(e), 16'd8);
        check_out("hs", 16'h0030, 16'hFFF0, 16'hFFF0, 16'hFFF0);
        dn = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done4) dn++;
        end
        check("hs.extra_done", 16'(dn), 16'd0);

        // Start held high: second done 9 edges after the first
        set_in(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0100, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done4 && n < 40);
        check("held.first_latency", 16'(n), 16'd9);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done4 && n < 40);
        start = 1'b0;
        check("held.spacing", 16'(n), 16'd9);
        check_out("held", 16'h0030, 16'hFFF0, 16'hFFF0, 16'hFFF0);

        // Reset mid-operation (during DOT)
        set_in(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst.busy", 16'(busy4), 16'd0);
        check("rst.done", 16'(done4), 16'd0);
        check_out("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done4) dn++;
        end
        check("rst.no_done", 16'(dn), 16'd0);
        set_in(16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0100, 16'h0, 16'h0, 16'h0);
        run4(-1, -1, 1'b0, e, b);
        check("rst_rerun.latency", 16'(e), 16'd8);
        check_out("rst_rerun", 16'h0030, 16'hFFF0, 16'hFFF0, 16'hFFF0);

        // VEC_SIZE = 1
        y1[0] = 16'h0100;
        g1[0] = 16'h0200;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("v1.busy", 16'(busy1), 16'd1);
        n = 0;
        while (!done1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("v1.latency", 16'(n), 16'd2);
        check("v1.s", dut1.s_reg, 16'h0200);
        check("v1.grad_out[0]", go1[0], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
